// File: rtl/pc_gen_pkg.sv
// ---------------------------------------------------------------------------
// pc_gen_pkg
// Shared CPU definitions used by the fetch PC generator and its BTB:
//   XLEN               - architectural register / address width
//   RESET_VECTOR_DEF   - default PC loaded on reset
//   btb_ctr_e          - 2-bit saturating branch-direction counter encoding
//   align_pc()         - clears bits [1:0] of a redirect / predicted target
// ---------------------------------------------------------------------------
package pc_gen_pkg;

   localparam int XLEN = 64;

   localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      SNT = 2'd0,   // strongly not-taken
      WNT = 2'd1,   // weakly not-taken
      WT  = 2'd2,   // weakly taken
      ST  = 2'd3    // strongly taken
   } btb_ctr_e;

   // Misaligned targets are reported by execute; fetch always sees a word address.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return addr & {{(XLEN-2){1'b1}}, 2'b00};
   endfunction

endpackage

// File: rtl/pc_gen_btb.sv
// ---------------------------------------------------------------------------
// btb_dm
// Direct-mapped branch target buffer with 2-bit saturating counters.
// One combinational read port, one synchronous write (training) port.
//   clk, rst        - clock, asynchronous active-high reset
//   rd_idx_i/tag_i  - lookup index and tag (from the current fetch PC)
//   rd_taken_o      - entry hits and its counter predicts taken
//   rd_target_o     - predicted target, 0 when not predicted taken
//   wr_valid_i      - execute resolved a control-transfer instruction
//   wr_idx_i/tag_i  - index and tag of the resolved instruction
//   wr_taken_i      - actual direction
//   wr_target_i     - actual taken target
// ---------------------------------------------------------------------------
module btb_dm
   import pc_gen_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int TAG_W   = 20,
   localparam int IDX_W  = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_i,
   input  logic [TAG_W-1:0] rd_tag_i,
   output logic             rd_taken_o,
   output logic [XLEN-1:0]  rd_target_o,
   input  logic             wr_valid_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic [TAG_W-1:0] wr_tag_i,
   input  logic             wr_taken_i,
   input  logic [XLEN-1:0]  wr_target_i
);

   logic             valid_q  [ENTRIES];
   btb_ctr_e         ctr_q    [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [XLEN-1:0]  target_q [ENTRIES];

   logic rd_hit;
   logic wr_hit;

   // Read sees the registered arrays, so a same-cycle write is visible next cycle.
   assign rd_hit      = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
   assign rd_taken_o  = rd_hit && ctr_q[rd_idx_i][1];
   assign rd_target_o = rd_taken_o ? target_q[rd_idx_i] : '0;

   assign wr_hit = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);

   // NOTE: every array is reset, not just valid: reset must leave the whole
   // table in a known state (counters SNT, tags and targets zero).
   // NOTE: sequential state uses non-blocking assignments so every entry
   // updates from pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            ctr_q[i]    <= SNT;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
         end
      end else if (wr_valid_i) begin
         if (wr_hit) begin
            if (wr_taken_i) begin
               ctr_q[wr_idx_i]    <= (ctr_q[wr_idx_i] == ST) ? ST
                                     : btb_ctr_e'(ctr_q[wr_idx_i] + 2'd1);
               target_q[wr_idx_i] <= align_pc(wr_target_i);
            end else begin
               ctr_q[wr_idx_i]    <= (ctr_q[wr_idx_i] == SNT) ? SNT
                                     : btb_ctr_e'(ctr_q[wr_idx_i] - 2'd1);
            end
         end else if (wr_taken_i) begin
            // Taken miss allocates (or evicts an alias); not-taken miss is ignored.
            valid_q[wr_idx_i]  <= 1'b1;
            tag_q[wr_idx_i]    <= wr_tag_i;
            ctr_q[wr_idx_i]    <= WT;
            target_q[wr_idx_i] <= align_pc(wr_target_i);
         end
      end
   end

endmodule

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Owns the architectural fetch PC and picks the next PC each cycle from
// trap, execute redirect, stall-hold, BTB prediction or pc+4.
//   clk, rst                - clock, asynchronous active-high reset
//   pc_stall                - hold pc (fetch/decode stalled)
//   trap_valid/target       - trap redirect (highest priority)
//   ex_redirect_valid/target- execute mispredict redirect
//   btb_upd_*               - BTB training from execute
//   pc                      - registered fetch PC
//   pc_o_pred_taken/target  - BTB prediction for the current pc
//   pc_o_flush              - redirect this cycle (fetch_bubble)
// ---------------------------------------------------------------------------
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter logic [63:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter int          BTB_ENTRIES  = 16,
   parameter int          TAG_W        = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_stall,
   input  logic        trap_valid,
   input  logic [63:0] trap_target,
   input  logic        ex_redirect_valid,
   input  logic [63:0] ex_redirect_target,
   input  logic        btb_upd_valid,
   input  logic [63:0] btb_upd_pc,
   input  logic        btb_upd_taken,
   input  logic [63:0] btb_upd_target,
   output logic [63:0] pc,
   output logic        pc_o_pred_taken,
   output logic [63:0] pc_o_pred_target,
   output logic        pc_o_flush
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_LO = IDX_W + 2;
   localparam int TAG_HI = TAG_W + IDX_W + 1;

   logic [63:0] pc_q;
   logic [63:0] pc_d;
   logic        unused_upd_bits;

   // Only index/tag bits of the training PC matter.
   assign unused_upd_bits = ^{btb_upd_pc[63:TAG_HI+1], btb_upd_pc[1:0]};

   btb_dm #(
      .ENTRIES (BTB_ENTRIES),
      .TAG_W   (TAG_W)
   ) u_btb (
      .clk         (clk),
      .rst         (rst),
      .rd_idx_i    (pc_q[IDX_W+1:2]),
      .rd_tag_i    (pc_q[TAG_HI:TAG_LO]),
      .rd_taken_o  (pc_o_pred_taken),
      .rd_target_o (pc_o_pred_target),
      .wr_valid_i  (btb_upd_valid),
      .wr_idx_i    (btb_upd_pc[IDX_W+1:2]),
      .wr_tag_i    (btb_upd_pc[TAG_HI:TAG_LO]),
      .wr_taken_i  (btb_upd_taken),
      .wr_target_i (btb_upd_target)
   );

   assign pc_o_flush = trap_valid | ex_redirect_valid;

   // Redirects outrank stall: the stalled younger work is being discarded.
   always_comb begin
      // NOTE: default first so every path assigns pc_d and no latch is inferred.
      pc_d = pc_q + 64'd4;
      if (trap_valid) begin
         pc_d = align_pc(trap_target);
      end else if (ex_redirect_valid) begin
         pc_d = align_pc(ex_redirect_target);
      end else if (pc_stall) begin
         pc_d = pc_q;
      end else if (pc_o_pred_taken) begin
         pc_d = align_pc(pc_o_pred_target);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc_q <= RESET_VECTOR;
      else     pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

   localparam logic [63:0] RV      = 64'h8000_0000;
   localparam int          ENTRIES = 16;
   localparam int          IDX_W   = 4;
   localparam int          TAG_W   = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_stall, trap_valid, ex_redirect_valid, btb_upd_valid, btb_upd_taken;
   logic [63:0] trap_target, ex_redirect_target, btb_upd_pc, btb_upd_target;
   logic [63:0] pc, pc_o_pred_target;
   logic        pc_o_pred_taken, pc_o_flush;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pc_gen dut (
      .clk                (clk),
      .rst                (rst),
      .pc_stall           (pc_stall),
      .trap_valid         (trap_valid),
      .trap_target        (trap_target),
      .ex_redirect_valid  (ex_redirect_valid),
      .ex_redirect_target (ex_redirect_target),
      .btb_upd_valid      (btb_upd_valid),
      .btb_upd_pc         (btb_upd_pc),
      .btb_upd_taken      (btb_upd_taken),
      .btb_upd_target     (btb_upd_target),
      .pc                 (pc),
      .pc_o_pred_taken    (pc_o_pred_taken),
      .pc_o_pred_target   (pc_o_pred_target),
      .pc_o_flush         (pc_o_flush)
   );

   typedef struct {
      logic        stall;
      logic        trap;
      logic [63:0] ttgt;
      logic        ex;
      logic [63:0] extgt;
      logic        upd;
      logic [63:0] upc;
      logic        utk;
      logic [63:0] utgt;
      logic [63:0] e_pc;
      logic        e_pt;
      logic [63:0] e_ptg;
      logic        e_fl;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic stall, input logic trap, input logic [63:0] ttgt,
                               input logic ex, input logic [63:0] extgt,
                               input logic upd, input logic [63:0] upc, input logic utk,
                               input logic [63:0] utgt, input logic [63:0] e_pc,
                               input logic e_pt, input logic [63:0] e_ptg, input logic e_fl);
      vec_t v;
      v.stall = stall; v.trap = trap; v.ttgt = ttgt; v.ex = ex; v.extgt = extgt;
      v.upd = upd; v.upc = upc; v.utk = utk; v.utgt = utgt;
      v.e_pc = e_pc; v.e_pt = e_pt; v.e_ptg = e_ptg; v.e_fl = e_fl;
      return v;
   endfunction

   task automatic idle_inputs();
      pc_stall = 0; trap_valid = 0; trap_target = '0; ex_redirect_valid = 0;
      ex_redirect_target = '0; btb_upd_valid = 0; btb_upd_pc = '0;
      btb_upd_taken = 0; btb_upd_target = '0;
   endtask

   // Called just after a falling edge: drive, check outputs mid-cycle, then
   // advance through the rising edge to the next falling edge.
   task automatic run_cycle(input string tag, input vec_t v);
      pc_stall = v.stall; trap_valid = v.trap; trap_target = v.ttgt;
      ex_redirect_valid = v.ex; ex_redirect_target = v.extgt;
      btb_upd_valid = v.upd; btb_upd_pc = v.upc; btb_upd_taken = v.utk;
      btb_upd_target = v.utgt;
      #1;
      check({tag, " pc"},        pc,               v.e_pc);
      check({tag, " pred"},      64'(pc_o_pred_taken), 64'(v.e_pt));
      check({tag, " pred_tgt"},  pc_o_pred_target, v.e_ptg);
      check({tag, " flush"},     64'(pc_o_flush),  64'(v.e_fl));
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- reference model (architectural view) ----------------
   logic [63:0] m_pc;
   logic        m_valid [ENTRIES];
   int          m_ctr   [ENTRIES];
   logic [63:0] m_tag   [ENTRIES];
   logic [63:0] m_tgt   [ENTRIES];

   function automatic int m_idx(input logic [63:0] p);
      return int'((p >> 2) % ENTRIES);
   endfunction

   function automatic logic [63:0] m_tagof(input logic [63:0] p);
      return (p >> (2 + IDX_W)) % (64'd1 << TAG_W);
   endfunction

   task automatic m_reset();
      m_pc = RV;
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 0; m_ctr[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
      end
   endtask

   task automatic m_lookup(input logic [63:0] p, output logic tk, output logic [63:0] tg);
      int i;
      i  = m_idx(p);
      tk = m_valid[i] && (m_tag[i] == m_tagof(p)) && (m_ctr[i] >= 2);
      tg = tk ? m_tgt[i] : 64'd0;
   endtask

   task automatic m_step(input vec_t v);
      logic        tk;
      logic [63:0] tg;
      int          i;
      m_lookup(m_pc, tk, tg);
      if (v.trap)       m_pc = v.ttgt - (v.ttgt % 4);
      else if (v.ex)    m_pc = v.extgt - (v.extgt % 4);
      else if (v.stall) m_pc = m_pc;
      else if (tk)      m_pc = tg - (tg % 4);
      else              m_pc = m_pc + 64'd4;
      if (v.upd) begin
         i = m_idx(v.upc);
         if (m_valid[i] && m_tag[i] == m_tagof(v.upc)) begin
            if (v.utk) begin
               m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
               m_tgt[i] = v.utgt;
            end else begin
               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
         end else if (v.utk) begin
            m_valid[i] = 1; m_tag[i] = m_tagof(v.upc); m_ctr[i] = 2; m_tgt[i] = v.utgt;
         end
      end
   endtask

   function automatic logic [63:0] rand_pc();
      return RV + 64'(4 * $urandom_range(0, 15)) + 64'(64 * $urandom_range(0, 2));
   endfunction

   vec_t tbl [27];

   initial begin
      vec_t v;
      logic tk;
      logic [63:0] tg;

      // Directed table; expected values are the outputs before each edge.
      //            stl tr ttgt                   ex extgt            up upc            tk utgt           e_pc                   pt ptg            fl
      tbl[0]  = mk(0, 0, 0,                     0, 0,               0, 0,             0, 0,             RV,                    0, 0,             0);
      tbl[1]  = mk(0, 0, 0,                     0, 0,               0, 0,             0, 0,             RV + 4,                0, 0,             0);
      tbl[2]  = mk(0, 0, 0,                     0, 0,               0, 0,             0, 0,             RV + 8,                0, 0,             0);
      tbl[3]  = mk(0, 0, 0,                     0, 0,               0, 0,             0, 0,             RV + 12,               0, 0,             0);
      tbl[4]  = mk(1, 0, 0,                     0, 0,               0, 0,             0, 0,             RV + 16,               0, 0,             0);
      tbl[5]  = mk(1, 0, 0,                     0, 0,               0, 0,             0, 0,             RV + 16,               0, 0,             0);
      tbl[6]  = mk(1, 0, 0,                     0, 0,               0, 0,             0, 0,             RV + 16,               0, 0,             0);
      tbl[7]  = mk(0, 0, 0,                     0, 0,               0, 0,             0, 0,             RV + 16,               0, 0,             0);
      tbl[8]  = mk(1, 1, 64'h8000_1000,         1, 64'h8000_2000,   0, 0,             0, 0,             RV + 20,               0, 0,             1);
      tbl[9]  = mk(0, 0, 0,                     0, 0,               1, 64'h8000_0020, 1, 64'h8000_0100, 64'h8000_1000,         0, 0,             0);
      tbl[10] = mk(0, 0, 0,                     1, 64'h8000_0020,   0, 0,             0, 0,             64'h8000_1004,         0, 0,             1);
      tbl[11] = mk(0, 0, 0,                     0, 0,               0, 0,             0, 0,             64'h8000_0020,         1, 64'h8000_0100, 0);
      tbl[12] = mk(0, 0, 0,                     0, 0,               1, 64'h8000_0020, 0, 0,             64'h8000_0100,         0, 0,             0);
      tbl[13] = mk(0, 0, 0,                     1, 64'h8000_0020,   1, 64'h8000_0020, 0, 0,             64'h8000_0104,         0, 0,             1);
      tbl[14] = mk(0, 0, 0,                     0, 0,               0, 0,             0, 0,             64'h8000_0020,         0, 0,             0);
      tbl[15] = mk(0, 0, 0,                     1, 64'h8000_0043,   0, 0,             0, 0,             64'h8000_0024,         0, 0,             1);
      tbl[16] = mk(0, 0, 0,                     0, 0,               1, 64'h8000_0040, 1, 64'h8000_0200, 64'h8000_0040,         0, 0,             0);
      tbl[17] = mk(0, 0, 0,                     1, 64'h8000_0040,   0, 0,             0, 0,             64'h8000_0044,         0, 0,             1);
      tbl[18] = mk(0, 0, 0,                     0, 0,               1, 64'h8000_1000, 1, 64'h8000_0300, 64'h8000_0040,         1, 64'h8000_0200, 0);
      tbl[19] = mk(0, 0, 0,                     1, 64'h8000_0040,   0, 0,             0, 0,             64'h8000_0200,         0, 0,             1);
      tbl[20] = mk(0, 0, 0,                     0, 0,               0, 0,             0, 0,             64'h8000_0040,         0, 0,             0);
      tbl[21] = mk(0, 0, 0,                     1, 64'h8000_1000,   0, 0,             0, 0,             64'h8000_0044,         0, 0,             1);
      tbl[22] = mk(0, 0, 0,                     0, 0,               0, 0,             0, 0,             64'h8000_1000,         1, 64'h8000_0300, 0);
      tbl[23] = mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0,             0, 0,             0, 0,             64'h8000_0300,         0, 0,             1);
      tbl[24] = mk(0, 0, 0,                     0, 0,               0, 0,             0, 0,             64'hFFFF_FFFF_FFFF_FFFC, 0, 0,            0);
      tbl[25] = mk(0, 0, 0,                     0, 0,               0, 0,             0, 0,             64'h0,                 0, 0,             0);
      tbl[26] = mk(0, 0, 0,                     0, 0,               0, 0,             0, 0,             64'h4,                 0, 0,             0);

      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("reset pc", pc, RV);
      check("reset pred", 64'(pc_o_pred_taken), 64'd0);
      check("reset pred_tgt", pc_o_pred_target, 64'd0);
      check("reset flush", 64'(pc_o_flush), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 27; i++) run_cycle($sformatf("vec%0d", i), tbl[i]);

      // Mid-run reset: asynchronous, clears PC and BTB.
      run_cycle("pre_rst", mk(0, 0, 0, 1, 64'h8000_1000, 0, 0, 0, 0, 64'h8, 0, 0, 1));
      run_cycle("pre_rst2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h8000_1000, 1, 64'h8000_0300, 0));
      #2;
      rst = 1'b1;
      #1;
      check("async rst pc", pc, RV);
      check("async rst pred", 64'(pc_o_pred_taken), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_cycle("post_rst0", mk(0, 0, 0, 1, 64'h8000_1000, 0, 0, 0, 0, RV, 0, 0, 1));
      run_cycle("post_rst1", mk(0, 0, 0, 1, 64'h8000_0020, 0, 0, 0, 0, 64'h8000_1000, 0, 0, 1));
      run_cycle("post_rst2", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h8000_0020, 0, 0, 0));

      // Random phase against the reference model.
      rst = 1'b1;
      #1;
      rst = 1'b0;
      m_reset();
      for (int n = 0; n < 600; n++) begin
         v.stall = ($urandom_range(0, 3) == 0);
         v.trap  = ($urandom_range(0, 15) == 0);
         v.ttgt  = rand_pc() + 64'($urandom_range(0, 3));
         v.ex    = ($urandom_range(0, 7) == 0);
         v.extgt = rand_pc() + 64'($urandom_range(0, 3));
         v.upd   = ($urandom_range(0, 1) == 0);
         v.upc   = rand_pc();
         v.utk   = ($urandom_range(0, 2) != 0);
         v.utgt  = rand_pc();
         m_lookup(m_pc, tk, tg);
         v.e_pc  = m_pc;
         v.e_pt  = tk;
         v.e_ptg = tg;
         v.e_fl  = v.trap | v.ex;
         run_cycle($sformatf("rnd%0d", n), v);
         m_step(v);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
